// File: rtl/mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_pkg: access-size encodings and controller state type
// Rev 1.0
// ------------------------------------------------------------------
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Offset of the last byte touched by an access of the given size.
  function automatic logic [1:0] size_last_off(input logic [1:0] size);
    case (size)
      SZ_H:    return 2'd1;
      SZ_W:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// byte_ram: byte array with 4-lane byte-enable write, async 4-byte read
// Rev 1.0
// ------------------------------------------------------------------
module byte_ram #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [7:0] r_mem [DEPTH_BYTES];

  // Lane i maps to byte address base+i; callers guarantee no wrap on writes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          r_mem[waddr + ADDR_W'(i)] <= wdata[8*i +: 8];
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rdata[8*gi +: 8] = r_mem[raddr + ADDR_W'(gi)];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ls.sv
`default_nettype none
// ------------------------------------------------------------------
// data_mem_ls: little-endian load/store data memory with wait states
// Rev 1.0
// ------------------------------------------------------------------
module data_mem_ls
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_addr_w    = $clog2(DEPTH_BYTES);
  localparam logic [3:0] c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_wait_cnt_nxt;
  logic                  r_we;
  logic                  r_unsigned;
  logic                  r_err;
  logic [1:0]            r_size;
  logic [c_addr_w-1:0]   r_addr;
  logic                  w_accept;
  logic                  w_err;
  logic                  w_wr;
  logic [32:0]           w_last_byte;
  logic [31:0]           w_rd;

  assign req_ready   = (r_state == ST_IDLE);
  assign w_accept    = rst_n && req_valid && req_ready;
  assign w_last_byte = {1'b0, req_addr} + {31'd0, size_last_off(req_size)};
  assign w_wr        = w_accept && req_we && !w_err;

  always_comb begin
    w_err = (w_last_byte >= 33'(DEPTH_BYTES));
    case (req_size)
      SZ_B:    ;
      SZ_H:    if (req_addr[0]) w_err = 1'b1;
      SZ_W:    if (req_addr[1:0] != 2'b00) w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // Stores commit straight from the request inputs on the accept edge.
  byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ADDR_W     (c_addr_w)
  ) u_ram (
    .clk  (clk),
    .we   (w_wr),
    .be   (size_be(req_size)),
    .waddr(req_addr[c_addr_w-1:0]),
    .wdata(req_wdata),
    .raddr(r_addr),
    .rdata(w_rd)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = c_wait_init;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_nxt = ST_RESP;
        else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_err      <= w_err;
      r_size     <= req_size;
      r_addr     <= req_addr[c_addr_w-1:0];
    end
  end

  assign rsp_valid = (r_state == ST_RESP);

  always_comb begin
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    if (rsp_valid) begin
      rsp_err = r_err;
      if (!r_err && !r_we) begin
        case (r_size)
          SZ_B:    rsp_rdata = {{24{w_rd[7] & ~r_unsigned}}, w_rd[7:0]};
          SZ_H:    rsp_rdata = {{16{w_rd[15] & ~r_unsigned}}, w_rd[15:0]};
          default: rsp_rdata = w_rd;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
